// File: rtl/hyperram_pkg.sv
// Shared types and constants for the HyperRAM responder: FSM states,
// command-address bit positions, burst-wrap geometry and CR0 defaults.
package hyperram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    RD,
    WR,
    RGW,
    DONE
  } state_t;

  // Bit positions within the 48-bit command-address word
  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  localparam int WRAP_BITS = 4;

  localparam int          CR0_ADDR    = 1;
  localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;

endpackage

// File: rtl/hyperram_responder_if.sv
// Core-clock word view of the HyperBus link between host controller and device.
interface hyperram_responder_if;
  logic        csn;
  logic        ck_en;
  logic [15:0] dq_in;
  logic [1:0]  rwds_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rwds_out;
  logic        rwds_oe;

  modport master (
    output csn, ck_en, dq_in, rwds_in,
    input  dq_out, dq_oe, rwds_out, rwds_oe
  );

  modport slave (
    input  csn, ck_en, dq_in, rwds_in,
    output dq_out, dq_oe, rwds_out, rwds_oe
  );
endinterface

// File: rtl/hyperram_resp_mem.sv
// Single-port synchronous RAM, 16-bit words with two byte enables and a
// registered read port (one-cycle read latency).
module hyperram_resp_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hyperram_responder.sv
// HyperRAM device-side responder: decodes CA, counts initial latency and
// serves read/write bursts from an internal array plus configuration register CR0.
module hyperram_responder
  import hyperram_pkg::*;
#(
  parameter int          AW         = 10,
  parameter int          LATENCY    = 6,
  parameter bit          DOUBLE_LAT = 1'b1,
  parameter logic [15:0] CR0_RST    = CR0_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  hyperram_responder_if.slave bus
);

  localparam int         L         = LATENCY * (DOUBLE_LAT ? 2 : 1);
  localparam logic [3:0] LAT_LAST  = 4'(L - 1);
  localparam logic [3:0] LAT_PREF  = 4'(L - 2);

  state_t        state;
  logic          ca_first;
  logic [15:0]   ca_hi;
  logic [15:0]   ca_mid;
  logic          is_rd;
  logic          is_reg;
  logic          is_lin;
  logic [3:0]    lat_cnt;
  logic [AW-1:0] addr;
  logic [15:0]   cr0;
  logic [15:0]   mem_q;
  logic          mem_we;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic lin);
    if (lin) return a + 1'b1;
    return {a[AW-1:WRAP_BITS], WRAP_BITS'(a[WRAP_BITS-1:0] + 1'b1)};
  endfunction

  assign mem_we = (state == WR) && bus.ck_en && !bus.csn && !rst;

  hyperram_resp_mem #(.AW(AW)) u_mem (
    .clk   (clk),
    .en    (bus.ck_en),
    .we    (mem_we),
    .be    (~bus.rwds_in),
    .addr  (addr),
    .wdata (bus.dq_in),
    .rdata (mem_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cr0          <= CR0_RST;
      ca_first     <= 1'b0;
      lat_cnt      <= '0;
      bus.dq_out   <= '0;
      bus.dq_oe    <= 1'b0;
      bus.rwds_out <= 1'b0;
      bus.rwds_oe  <= 1'b0;
    end else if (bus.csn) begin
      state        <= IDLE;
      bus.dq_oe    <= 1'b0;
      bus.rwds_out <= 1'b0;
      bus.rwds_oe  <= 1'b0;
    end else if (bus.ck_en) begin
      bus.dq_oe    <= 1'b0;
      bus.rwds_out <= 1'b0;
      bus.rwds_oe  <= 1'b0;
      case (state)
        IDLE: begin
          ca_hi        <= bus.dq_in;
          ca_first     <= 1'b1;
          state        <= CA;
          bus.rwds_oe  <= 1'b1;
          bus.rwds_out <= DOUBLE_LAT;
        end
        CA: begin
          bus.rwds_oe  <= 1'b1;
          bus.rwds_out <= DOUBLE_LAT;
          if (ca_first) begin
            ca_mid   <= bus.dq_in;
            ca_first <= 1'b0;
          end else begin
            is_rd   <= ca_hi[CA_RW-32];
            is_reg  <= ca_hi[CA_AS-32];
            is_lin  <= ca_hi[CA_BT-32];
            addr    <= AW'({ca_hi[12:0], ca_mid, bus.dq_in[2:0]});
            lat_cnt <= '0;
            state   <= (!ca_hi[CA_RW-32] && ca_hi[CA_AS-32]) ? RGW : LAT;
          end
        end
        LAT: begin
          // Reads start walking the array two cycles early so the RAM's
          // registered output lines up with the first data beat.
          if (is_rd && lat_cnt >= LAT_PREF) addr <= next_addr(addr, is_lin);
          if (lat_cnt == LAT_LAST) begin
            state <= is_rd ? RD : WR;
            if (is_rd) begin
              bus.dq_out   <= is_reg ? cr0 : mem_q;
              bus.dq_oe    <= 1'b1;
              bus.rwds_oe  <= 1'b1;
              bus.rwds_out <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RD: begin
          addr         <= next_addr(addr, is_lin);
          bus.dq_out   <= is_reg ? cr0 : mem_q;
          bus.dq_oe    <= 1'b1;
          bus.rwds_oe  <= 1'b1;
          bus.rwds_out <= 1'b1;
        end
        WR: addr <= next_addr(addr, is_lin);
        RGW: begin
          if (addr == AW'(CR0_ADDR)) cr0 <= bus.dq_in;
          state <= DONE;
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder with a read-data scoreboard.
module tb_hyperram_responder;

  localparam int L = 12;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] sb[$];
  logic [17:0] wq[$];

  hyperram_responder_if bus ();

  hyperram_responder #(
    .AW(10), .LATENCY(6), .DOUBLE_LAT(1'b1), .CR0_RST(16'h8F1F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One core-clock cycle; read beats are popped from the scoreboard as they appear
  task automatic cyc(input logic c, input logic e, input logic [15:0] d, input logic [1:0] m);
    bus.csn = c; bus.ck_en = e; bus.dq_in = d; bus.rwds_in = m;
    @(posedge clk);
    #1;
    if (e && bus.dq_oe === 1'b1) begin
      if (sb.size() == 0) chk1("unexpected_beat", bus.dq_oe, 1'b0);
      else begin
        chk16("rd_data", bus.dq_out, sb.pop_front());
        chk1("rd_strobe", bus.rwds_out, 1'b1);
      end
    end
  endtask

  task automatic send_ca(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    cyc(1'b0, 1'b1, w0, 2'b00);
    chk1("ca0_rwds_oe", bus.rwds_oe, 1'b1);
    chk1("ca0_rwds_out", bus.rwds_out, 1'b1);
    cyc(1'b0, 1'b1, w1, 2'b00);
    chk1("ca1_rwds_oe", bus.rwds_oe, 1'b1);
    cyc(1'b0, 1'b1, w2, 2'b00);
    chk1("ca2_rwds_oe", bus.rwds_oe, 1'b1);
  endtask

  task automatic read_burst(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input int n);
    send_ca(w0, w1, w2);
    for (int i = 0; i < L - 1; i++) begin
      cyc(1'b0, 1'b1, 16'h0000, 2'b00);
      if (i == 0) chk1("lat_rwds_oe", bus.rwds_oe, 1'b0);
    end
    chk1("lat_dq_oe_quiet", bus.dq_oe, 1'b0);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 16'h0000, 2'b00);
    chk1("rd_dq_oe", bus.dq_oe, 1'b1);
    cyc(1'b1, 1'b1, 16'h0000, 2'b00);
    chk1("end_dq_oe", bus.dq_oe, 1'b0);
    chk16("sb_drained", 16'(sb.size()), 16'd0);
  endtask

  task automatic write_burst(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    logic [17:0] e;
    send_ca(w0, w1, w2);
    for (int i = 0; i < L; i++) cyc(1'b0, 1'b1, 16'hDEAD, 2'b00);
    while (wq.size() > 0) begin
      e = wq.pop_front();
      cyc(1'b0, 1'b1, e[17:2], e[1:0]);
    end
    chk1("wr_dq_oe", bus.dq_oe, 1'b0);
    cyc(1'b1, 1'b1, 16'h0000, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    bus.csn = 1'b1; bus.ck_en = 1'b0; bus.dq_in = '0; bus.rwds_in = '0;
    cyc(1'b1, 1'b1, 16'h0000, 2'b00);
    cyc(1'b1, 1'b1, 16'h0000, 2'b00);
    chk16("rst_dq_out", bus.dq_out, 16'h0000);
    chk1("rst_dq_oe", bus.dq_oe, 1'b0);
    chk1("rst_rwds_out", bus.rwds_out, 1'b0);
    chk1("rst_rwds_oe", bus.rwds_oe, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 16'h0000, 2'b00);

    // CR0 reset value, then register write with zero latency and readback
    sb.push_back(16'h8F1F);
    read_burst(16'hC000, 16'h0000, 16'h0000, 1);
    send_ca(16'h6000, 16'h0000, 16'h0001);
    cyc(1'b0, 1'b1, 16'h8F0F, 2'b00);
    chk1("rgw_dq_oe", bus.dq_oe, 1'b0);
    chk1("rgw_rwds_oe", bus.rwds_oe, 1'b0);
    cyc(1'b0, 1'b1, 16'h1234, 2'b00);
    chk1("done_dq_oe", bus.dq_oe, 1'b0);
    cyc(1'b1, 1'b1, 16'h0000, 2'b00);
    sb.push_back(16'h8F0F);
    read_burst(16'hC000, 16'h0000, 16'h0000, 1);

    // Preload words 0..63 with their own address
    for (int i = 0; i < 64; i++) wq.push_back({16'(i), 2'b00});
    write_burst(16'h2000, 16'h0000, 16'h0000);

    // Wrapped read from 0x1E crosses the 16-word boundary
    foreach (sb[i]) sb.delete(i);
    sb.push_back(16'h001E); sb.push_back(16'h001F); sb.push_back(16'h0010);
    sb.push_back(16'h0011); sb.push_back(16'h0012); sb.push_back(16'h0013);
    read_burst(16'h8000, 16'h0003, 16'h0006, 6);

    // Linear write at 0x10 with the low byte of the third word masked
    wq.push_back({16'h1111, 2'b00}); wq.push_back({16'h2222, 2'b00});
    wq.push_back({16'h3333, 2'b01}); wq.push_back({16'h4444, 2'b00});
    write_burst(16'h2000, 16'h0002, 16'h0000);
    sb.push_back(16'h1111); sb.push_back(16'h2222);
    sb.push_back(16'h3312); sb.push_back(16'h4444);
    read_burst(16'hA000, 16'h0002, 16'h0000, 4);

    // Stall mid-burst, then abort after two beats and start a new command at once
    sb.push_back(16'h0020); sb.push_back(16'h0021);
    send_ca(16'hA000, 16'h0004, 16'h0000);
    for (int i = 0; i < L; i++) cyc(1'b0, 1'b1, 16'h0000, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'h0000, 2'b00);
      chk16("stall_hold_data", bus.dq_out, 16'h0020);
      chk1("stall_hold_oe", bus.dq_oe, 1'b1);
    end
    cyc(1'b0, 1'b1, 16'h0000, 2'b00);
    cyc(1'b1, 1'b1, 16'h0000, 2'b00);
    chk1("abort_dq_oe", bus.dq_oe, 1'b0);
    chk1("abort_rwds_oe", bus.rwds_oe, 1'b0);
    chk16("abort_sb_drained", 16'(sb.size()), 16'd0);
    sb.push_back(16'h8F0F);
    read_burst(16'hC000, 16'h0000, 16'h0000, 1);

    // Reset in the middle of a write burst
    send_ca(16'h2000, 16'h0006, 16'h0000);
    for (int i = 0; i < L; i++) cyc(1'b0, 1'b1, 16'hDEAD, 2'b00);
    cyc(1'b0, 1'b1, 16'hA0A0, 2'b00);
    cyc(1'b0, 1'b1, 16'hB1B1, 2'b00);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 16'hC2C2, 2'b00);
    chk16("midrst_dq_out", bus.dq_out, 16'h0000);
    chk1("midrst_dq_oe", bus.dq_oe, 1'b0);
    chk1("midrst_rwds_oe", bus.rwds_oe, 1'b0);
    chk1("midrst_rwds_out", bus.rwds_out, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 16'hD3D3, 2'b00);
    sb.push_back(16'hA0A0); sb.push_back(16'hB1B1);
    sb.push_back(16'h0032); sb.push_back(16'h0033);
    read_burst(16'hA000, 16'h0006, 16'h0000, 4);
    sb.push_back(16'h8F1F);
    read_burst(16'hC000, 16'h0000, 16'h0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
